seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised, runtime-programmable serial bit-pattern detector. Successor to the fixed 4-bit Mealy detectors. Pattern, pattern length and overlap mode load through a configuration strobe. Detection is Mealy-style (asserted in the same cycle as the final pattern bit), with an input-valid qualifier and a saturating match counter. Sits on a serial input stream between a bit source (deserialiser or test driver) and control/status logic.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits; legal range 2..32.
- CNT_W, 8: width of the match counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- din  in  1  serial data bit; sampled only when din_valid=1.
- din_valid  in  1  qualifies din; one bit accepted per cycle with din_valid=1.
- cfg_load  in  1  one-cycle strobe; latches pattern, pat_len and overlap.
- pattern  in  MAX_LEN  target pattern; pattern[pat_len-1] is the first bit received, pattern[0] the last.
- pat_len  in  $clog2(MAX_LEN)+1  pattern length in bits.
- overlap  in  1  1 = overlapping detection; 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  combinational Mealy output; high in the cycle the final pattern bit is accepted.
- match_cnt  out  CNT_W  registered count of matches; saturates at all-ones.
- cfg_err  out  1  registered; high while the latched pat_len is 0, 1 or greater than MAX_LEN.

## Operation
- Internal registers:
  - pat_r, len_r, ovl_r: latched configuration.
  - hist[MAX_LEN-1:0]: history shift register; the newest bit enters at the LSB.
  - fill: saturating count of bits accepted since the last clear; range 0..MAX_LEN.
- cfg_load=1:
  - Latch the configuration.
  - Clear hist and fill.
  - Ignore din_valid in this cycle; match=0.
  - match_cnt is not affected.
- Bit accept (din_valid=1, cfg_load=0):
  - hist <= {hist[MAX_LEN-2:0], din}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated combinationally in the accept cycle:
  - cfg_err=0 and fill+1 >= len_r.
  - The low len_r bits of {hist, din} equal pat_r[len_r-1:0].
  - Compare only the low len_r bits; bits above len_r are don't-care.
- On match:
  - match=1.
  - match_cnt increments by 1 unless it is already all-ones.
  - If ovl_r=0, fill <= 0 in place of fill+1, so the next match needs len_r fresh bits.
  - If ovl_r=1, fill updates normally and hist is kept.
- din_valid=0: no state change; match=0.
- cnt_clr=1: match_cnt <= 0, with priority over an increment in the same cycle. The detector state still updates.
- cfg_err=1: match never asserts; hist and fill keep running.

## Timing
- Reset values:
  - pat_r=0, len_r=0, ovl_r=0, hist=0, fill=0, match_cnt=0.
  - cfg_err=1, because len_r=0 is invalid.
  - match=0.
- Latency:
  - match has zero latency from the accepting edge; it is combinational from din, din_valid and state.
  - match_cnt and fill reflect the match after the next rising edge.
- Configuration timing:
  - Values latched on edge N take effect for the bit accepted at edge N+1 and later.
  - cfg_err updates at edge N.
- Simultaneous events:
  - cfg_load with din_valid: configuration wins and the bit is dropped.
  - cnt_clr with a match: match=1 is still shown, and match_cnt becomes 0.
- Reset mid-stream: any partial pattern in progress is lost; detection restarts from fill=0.
- Non-overlap with a match on the last bit: the following bit starts fill at 1.
- Saturation:
  - fill stops at MAX_LEN.
  - match_cnt stops at 2^CNT_W-1 and never wraps.

## Test plan
- Overlap case:
  - Stimulus: cfg pattern=4'b1101, pat_len=4, overlap=1; stream 1,1,0,1,1,0,1, all valid.
  - Required: match on bits 4 and 7; match_cnt=2.
- Non-overlap case:
  - Stimulus: same stream with overlap=0.
  - Required: match on bit 4 only; match_cnt=1.
- Gapped input and full-width pattern:
  - Stimulus: pattern=8'hA5, pat_len=8; stream 1,0,1,0,0,1,0,1 with din_valid=0 gaps between bits.
  - Required: a single match, on the eighth valid bit; no match in any gap cycle.
- Invalid length, then reload mid-stream:
  - Stimulus: pat_len=0, then 1, then 9 (MAX_LEN=8); afterwards pat_len=3, pattern=3'b111, fed bits 1,1 then cfg_load then 1.
  - Required: cfg_err=1 and no match for lengths 0, 1 and 9. After the reload, no match, because hist was cleared.
- Counter saturation and clear (CNT_W=2):
  - Stimulus: 5 matches, then cnt_clr asserted in the same cycle as a 6th match.
  - Required: match_cnt goes 1,2,3,3,3, then 0; match=1 in the clear cycle.
- Asynchronous reset mid-pattern:
  - Stimulus: assert reset asynchronously after bits 1,1,0 of 1101.
  - Required: all outputs at reset values. Post-reset cfg_err=1 until the next cfg_load.

Source files
------------

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Runtime-programmable serial bit-pattern detector with Mealy-style match
// output. A pattern, its length and the overlap mode are latched on a
// one-cycle configuration strobe. Incoming bits are qualified by din_valid
// and shifted into a history register. A match is flagged combinationally in
// the cycle that the final pattern bit is accepted. Matches are counted in a
// saturating counter.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   din        serial data bit, sampled when din_valid=1
//   din_valid  qualifies din
//   cfg_load   one-cycle strobe that latches pattern / pat_len / overlap
//   pattern    target pattern; pattern[pat_len-1] is the oldest bit
//   pat_len    pattern length in bits (legal 2..MAX_LEN)
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   cnt_clr    synchronous clear of match_cnt (wins over an increment)
//   match      combinational match flag for the bit being accepted
//   match_cnt  registered saturating match count
//   cfg_err    registered flag: latched length is outside 2..MAX_LEN
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    input  logic                      din_valid,
    input  logic                      cfg_load,
    input  logic [MAX_LEN-1:0]        pattern,
    input  logic [$clog2(MAX_LEN):0]  pat_len,
    input  logic                      overlap,
    input  logic                      cnt_clr,
    output logic                      match,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      cfg_err
);

    localparam int LEN_W  = $clog2(MAX_LEN) + 1;
    localparam int FILL_W = $clog2(MAX_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);

    // Mask selecting the low 'len' bits of the comparison window.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    // A length is usable only in the range 2..MAX_LEN.
    function automatic logic len_invalid(input logic [LEN_W-1:0] len);
        return (int'(len) < 2) || (int'(len) > MAX_LEN);
    endfunction

    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    logic [MAX_LEN-1:0] hist_r;
    logic [FILL_W-1:0]  fill_r;
    logic [CNT_W-1:0]   match_cnt_r;
    logic               cfg_err_r;

    logic [MAX_LEN-1:0] window_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               accept_s;
    logic               fill_ok_s;
    logic               pat_eq_s;
    logic               match_s;

    // Combinational match: window is the history with the incoming bit appended.
    always_comb begin
        window_s  = {hist_r[MAX_LEN-2:0], din};
        mask_s    = len_mask(len_r);
        accept_s  = din_valid & ~cfg_load;
        fill_ok_s = (int'(fill_r) + 1) >= int'(len_r);
        pat_eq_s  = ((window_s ^ pat_r) & mask_s) == '0;
        if (accept_s && !cfg_err_r && fill_ok_s && pat_eq_s) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // Configuration, history, fill level and match counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_r       <= '0;
            len_r       <= '0;
            ovl_r       <= 1'b0;
            hist_r      <= '0;
            fill_r      <= '0;
            match_cnt_r <= '0;
            cfg_err_r   <= 1'b1;
        end else begin
            if (cfg_load) begin
                // Configuration wins over a coincident data bit.
                pat_r     <= pattern;
                len_r     <= pat_len;
                ovl_r     <= overlap;
                hist_r    <= '0;
                fill_r    <= '0;
                cfg_err_r <= len_invalid(pat_len);
            end else if (din_valid) begin
                hist_r <= window_s;
                // Non-overlapping mode restarts the fill count after a match.
                if (match_s && !ovl_r) begin
                    fill_r <= '0;
                end else if (fill_r != FILL_MAX) begin
                    fill_r <= fill_r + FILL_W'(1);
                end else begin
                    fill_r <= fill_r;
                end
            end else begin
                hist_r <= hist_r;
                fill_r <= fill_r;
            end

            if (cnt_clr) begin
                match_cnt_r <= '0;
            end else if (match_s && (match_cnt_r != '1)) begin
                match_cnt_r <= match_cnt_r + CNT_W'(1);
            end else begin
                match_cnt_r <= match_cnt_r;
            end
        end
    end

    assign match     = match_s;
    assign match_cnt = match_cnt_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Directed self-checking bench for seq_detector_param (MAX_LEN=8, CNT_W=2).
// A behavioural reference model predicts match, match_cnt and cfg_err for
// every driven cycle; predictions are queued at drive time and popped when
// the DUT outputs are sampled.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       cfg_load;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic       overlap;
    logic       cnt_clr;
    logic       match;
    logic [1:0] match_cnt;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_pat;
    int         m_len;
    logic       m_ovl;
    logic [7:0] m_hist;
    int         m_fill;
    int         m_cnt;
    logic       m_err;

    // Scoreboard queues
    logic       exp_match_q[$];
    logic [1:0] exp_cnt_q[$];
    logic       exp_err_q[$];

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .cfg_load  (cfg_load),
        .pattern   (pattern),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .cnt_clr   (cnt_clr),
        .match     (match),
        .match_cnt (match_cnt),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat = '0; m_len = 0; m_ovl = 1'b0; m_hist = '0;
        m_fill = 0; m_cnt = 0; m_err = 1'b1;
    endtask

    // One clock cycle of stimulus: predict, drive, then compare.
    task automatic step(input logic d, input logic v, input logic cl,
                        input logic [7:0] p, input logic [3:0] l,
                        input logic o, input logic cc);
        logic [7:0] win;
        logic       em;
        din = d; din_valid = v; cfg_load = cl;
        pattern = p; pat_len = l; overlap = o; cnt_clr = cc;

        win = {m_hist[6:0], d};
        em  = 1'b0;
        if (!cl && v && !m_err && (m_fill + 1 >= m_len)) begin
            em = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (i < m_len && win[i] !== m_pat[i]) em = 1'b0;
            end
        end
        if (cl) begin
            m_pat = p; m_len = int'(l); m_ovl = o; m_hist = '0; m_fill = 0;
            m_err = (l < 4'd2) || (l > 4'd8);
        end else if (v) begin
            m_hist = win;
            if (em && !m_ovl) m_fill = 0;
            else if (m_fill < 8) m_fill = m_fill + 1;
        end
        if (cc) m_cnt = 0;
        else if (em && m_cnt != 3) m_cnt = m_cnt + 1;

        exp_match_q.push_back(em);
        exp_cnt_q.push_back(2'(m_cnt));
        exp_err_q.push_back(m_err);

        #2;
        chk("match", 32'(match), 32'(exp_match_q.pop_front()));
        @(posedge clk);
        #1;
        chk("match_cnt", 32'(match_cnt), 32'(exp_cnt_q.pop_front()));
        chk("cfg_err", 32'(cfg_err), 32'(exp_err_q.pop_front()));
        @(negedge clk);
        din_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
        step(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
    endtask

    task automatic bit_in(input logic d);
        step(d, 1'b1, 1'b0, pattern, pat_len, overlap, 1'b0);
    endtask

    task automatic gap();
        step(1'b0, 1'b0, 1'b0, pattern, pat_len, overlap, 1'b0);
    endtask

    task automatic clr();
        step(1'b0, 1'b0, 1'b0, pattern, pat_len, overlap, 1'b1);
    endtask

    initial begin
        logic [6:0] s1;
        logic [7:0] s3;
        s1 = 7'b1101101;
        s3 = 8'hA5;
        reset = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
        pattern = '0; pat_len = '0; overlap = 1'b0; cnt_clr = 1'b0;
        model_reset();

        // Reset state
        #2;
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Overlapping 1101 over 1101101: matches on bits 4 and 7
        cfg(8'b0000_1101, 4'd4, 1'b1);
        for (int i = 6; i >= 0; i--) bit_in(s1[i]);
        chk("ovl_total", 32'(match_cnt), 32'd2);
        clr();

        // Non-overlapping: match on bit 4 only
        cfg(8'b0000_1101, 4'd4, 1'b0);
        for (int i = 6; i >= 0; i--) bit_in(s1[i]);
        chk("novl_total", 32'(match_cnt), 32'd1);
        clr();

        // Full-width pattern with idle gaps between valid bits
        cfg(8'hA5, 4'd8, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            bit_in(s3[i]);
            gap();
        end
        chk("gap_total", 32'(match_cnt), 32'd1);
        clr();

        // Illegal lengths 0, 1 and 9 never match
        cfg(8'h00, 4'd0, 1'b1);
        chk("err_len0", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 4; i++) bit_in(1'b0);
        cfg(8'h01, 4'd1, 1'b1);
        chk("err_len1", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 4; i++) bit_in(1'b1);
        cfg(8'hFF, 4'd9, 1'b1);
        chk("err_len9", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 10; i++) bit_in(1'b1);
        chk("err_total", 32'(match_cnt), 32'd0);

        // Reload mid-stream clears history; coincident bit is dropped
        cfg(8'b0000_0111, 4'd3, 1'b1);
        bit_in(1'b1);
        bit_in(1'b1);
        step(1'b1, 1'b1, 1'b1, 8'b0000_0111, 4'd3, 1'b1, 1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b1);
        chk("reload_total", 32'(match_cnt), 32'd1);
        clr();

        // Counter saturation at 3, then clear coincident with a match
        cfg(8'b0000_0011, 4'd2, 1'b1);
        for (int i = 0; i < 6; i++) bit_in(1'b1);
        chk("sat_cnt", 32'(match_cnt), 32'd3);
        step(1'b1, 1'b1, 1'b0, pattern, pat_len, overlap, 1'b1);
        chk("clr_cnt", 32'(match_cnt), 32'd0);

        // Asynchronous reset in the middle of a partial pattern
        cfg(8'b0000_1101, 4'd4, 1'b1);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_cnt", 32'(match_cnt), 32'd0);
        chk("arst_err", 32'(cfg_err), 32'd1);
        chk("arst_match", 32'(match), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        bit_in(1'b1);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        chk("post_rst_cnt", 32'(match_cnt), 32'd0);
        cfg(8'b0000_1101, 4'd4, 1'b1);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        chk("post_cfg_cnt", 32'(match_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
